// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random pre-delay, GO phase with a BCD millisecond count,
// false-start detection and best-time tracking for the seven-segment path.
module reaction_timer_ctrl #(
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_SCALE  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_ms,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic [6:0]  rand_in,
    output logic        led_go,
    output logic        running,
    output logic        false_start,
    output logic [15:0] bcd_time,
    output logic [15:0] best_bcd,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FOUL  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] best_q, best_d;
    logic        fs_q, fs_d;
    logic        led_q, led_d;
    logic        run_q, run_d;
    logic [15:0] delay_load;
    logic [15:0] bcd_inc;
    logic        carry;

    assign delay_load = 16'(MIN_DELAY_MS) + 16'(rand_in) * 16'(DELAY_SCALE);

    // Ripple increment across the four digits; holds at 9999.
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b0;
        if (bcd_q != 16'h9999) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        bcd_inc[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        bcd_d   = bcd_q;
        best_d  = best_q;
        fs_d    = fs_q;

        case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (start_btn) begin
                    state_d = S_DELAY;
                    delay_d = delay_load;
                    bcd_d   = '0;
                    fs_d    = 1'b0;
                end
            end
            S_DELAY: begin
                if (stop_btn) begin
                    state_d = S_FOUL;
                    fs_d    = 1'b1;
                end else if (tick_ms) begin
                    delay_d = (delay_q == 16'd0) ? 16'd0 : delay_q - 16'd1;
                    if (delay_q <= 16'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (stop_btn) begin
                    state_d = S_DONE;
                    if (bcd_q < best_q) begin
                        best_d = bcd_q;
                    end
                end else if (tick_ms) begin
                    bcd_d = bcd_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        led_d = (state_d == S_RUN);
        run_d = (state_d == S_DELAY) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            delay_q <= '0;
            bcd_q   <= '0;
            best_q  <= 16'h9999;
            fs_q    <= 1'b0;
            led_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            bcd_q   <= bcd_d;
            best_q  <= best_d;
            fs_q    <= fs_d;
            led_q   <= led_d;
            run_q   <= run_d;
        end
    end

    assign led_go      = led_q;
    assign running     = run_q;
    assign false_start = fs_q;
    assign bcd_time    = bcd_q;
    assign best_bcd    = best_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: vector table, directed corner sequences and a
// randomized run against an integer-arithmetic reference model.
module tb_reaction_timer_ctrl;

    localparam int MIN   = 4;
    localparam int SCALE = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_ms = 1'b0;
    logic        start_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic [6:0]  rand_in = '0;
    logic        led_go, running, false_start;
    logic [15:0] bcd_time, best_bcd;
    logic [2:0]  state_o;

    reaction_timer_ctrl #(
        .MIN_DELAY_MS(MIN),
        .DELAY_SCALE (SCALE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_ms    (tick_ms),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .rand_in    (rand_in),
        .led_go     (led_go),
        .running    (running),
        .false_start(false_start),
        .bcd_time   (bcd_time),
        .best_bcd   (best_bcd),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic led_seen = 1'b0;

    // Reference model: phase uses the documented state codes, times kept as integers.
    int m_phase, m_remain, m_elapsed, m_best;
    logic m_fs;

    function automatic logic [15:0] to_bcd(input int n);
        to_bcd = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_remain = 0; m_elapsed = 0; m_best = 9999; m_fs = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic tk, input logic [6:0] r);
        case (m_phase)
            1: begin
                if (sp) begin
                    m_phase = 4; m_fs = 1'b1;
                end else if (tk) begin
                    m_remain = m_remain - 1;
                    if (m_remain <= 0) m_phase = 2;
                end
            end
            2: begin
                if (sp) begin
                    m_phase = 3;
                    if (m_elapsed < m_best) m_best = m_elapsed;
                end else if (tk && m_elapsed < 9999) begin
                    m_elapsed = m_elapsed + 1;
                end
            end
            default: begin
                if (st) begin
                    m_phase = 1; m_remain = MIN + int'(r) * SCALE; m_elapsed = 0; m_fs = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"}, 16'(state_o), 16'(m_phase));
        check({tag, ".bcd"}, bcd_time, to_bcd(m_elapsed));
        check({tag, ".best"}, best_bcd, to_bcd(m_best));
        check({tag, ".led"}, 16'(led_go), 16'(m_phase == 2));
        check({tag, ".running"}, 16'(running), 16'(m_phase == 1 || m_phase == 2));
        check({tag, ".fs"}, 16'(false_start), 16'(m_fs));
    endtask

    task automatic cycle(input logic st, input logic sp, input logic tk, input logic [6:0] r);
        @(negedge clk);
        start_btn = st; stop_btn = sp; tick_ms = tk; rand_in = r;
        model_step(st, sp, tk, r);
        @(posedge clk);
        #1;
        start_btn = 1'b0; stop_btn = 1'b0; tick_ms = 1'b0;
        if (led_go) led_seen = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Full round: start, wait out the pre-delay, count n ticks, stop.
    task automatic run_round(input logic [6:0] r, input int n);
        cycle(1'b1, 1'b0, 1'b0, r);
        for (int i = 0; i < MIN + int'(r) * SCALE; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    typedef struct {
        logic        st, sp, tk;
        logic [6:0]  r;
        logic [2:0]  e_state;
        logic [15:0] e_bcd, e_best;
        logic        e_led, e_fs;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic st, input logic sp, input logic tk, input logic [6:0] r,
                                input logic [2:0] es, input logic [15:0] eb, input logic [15:0] ebest,
                                input logic el, input logic ef);
        vec_t v;
        v.st = st; v.sp = sp; v.tk = tk; v.r = r;
        v.e_state = es; v.e_bcd = eb; v.e_best = ebest; v.e_led = el; v.e_fs = ef;
        return v;
    endfunction

    initial begin
        logic st, sp, tk;

        tbl[0]  = mk(1, 0, 0, 7'd0, 3'd1, 16'h0000, 16'h9999, 0, 0);
        tbl[1]  = mk(0, 0, 1, 7'd0, 3'd1, 16'h0000, 16'h9999, 0, 0);
        tbl[2]  = mk(0, 0, 1, 7'd0, 3'd1, 16'h0000, 16'h9999, 0, 0);
        tbl[3]  = mk(0, 0, 1, 7'd0, 3'd1, 16'h0000, 16'h9999, 0, 0);
        tbl[4]  = mk(0, 0, 1, 7'd0, 3'd2, 16'h0000, 16'h9999, 1, 0);
        tbl[5]  = mk(0, 0, 1, 7'd0, 3'd2, 16'h0001, 16'h9999, 1, 0);
        tbl[6]  = mk(1, 0, 0, 7'd0, 3'd2, 16'h0001, 16'h9999, 1, 0);
        tbl[7]  = mk(0, 0, 1, 7'd0, 3'd2, 16'h0002, 16'h9999, 1, 0);
        tbl[8]  = mk(0, 1, 1, 7'd0, 3'd3, 16'h0002, 16'h0002, 0, 0);
        tbl[9]  = mk(0, 1, 0, 7'd0, 3'd3, 16'h0002, 16'h0002, 0, 0);
        tbl[10] = mk(0, 0, 1, 7'd0, 3'd3, 16'h0002, 16'h0002, 0, 0);
        tbl[11] = mk(1, 1, 0, 7'd1, 3'd1, 16'h0000, 16'h0002, 0, 0);
        tbl[12] = mk(0, 0, 1, 7'd0, 3'd1, 16'h0000, 16'h0002, 0, 0);
        tbl[13] = mk(0, 1, 1, 7'd0, 3'd4, 16'h0000, 16'h0002, 0, 1);
        tbl[14] = mk(0, 0, 1, 7'd0, 3'd4, 16'h0000, 16'h0002, 0, 1);
        tbl[15] = mk(1, 1, 0, 7'd0, 3'd1, 16'h0000, 16'h0002, 0, 0);
        tbl[16] = mk(0, 1, 0, 7'd0, 3'd4, 16'h0000, 16'h0002, 0, 1);

        // Post-reset state
        do_reset();
        check("rst.state", 16'(state_o), 16'd0);
        check("rst.bcd", bcd_time, 16'h0000);
        check("rst.best", best_bcd, 16'h9999);
        check("rst.led", 16'(led_go), 16'd0);
        check("rst.running", 16'(running), 16'd0);
        check("rst.fs", 16'(false_start), 16'd0);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].st, tbl[i].sp, tbl[i].tk, tbl[i].r);
            check($sformatf("vec%0d.state", i), 16'(state_o), 16'(tbl[i].e_state));
            check($sformatf("vec%0d.bcd", i), bcd_time, tbl[i].e_bcd);
            check($sformatf("vec%0d.best", i), best_bcd, tbl[i].e_best);
            check($sformatf("vec%0d.led", i), 16'(led_go), 16'(tbl[i].e_led));
            check($sformatf("vec%0d.fs", i), 16'(false_start), 16'(tbl[i].e_fs));
            check($sformatf("vec%0d.running", i), 16'(running),
                  16'(tbl[i].e_state == 3'd1 || tbl[i].e_state == 3'd2));
        end

        // Normal round: rand 3 -> GO on the 7th tick, then 250 ticks
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 7'd3);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        check("go.before7", 16'(led_go), 16'd0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("go.at7", 16'(led_go), 16'd1);
        for (int i = 0; i < 250; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("round.bcd", bcd_time, 16'h0250);
        check("round.best", best_bcd, 16'h0250);
        check("round.state", 16'(state_o), 16'd3);

        // False start
        led_seen = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 7'd5);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("foul.state", 16'(state_o), 16'd4);
        check("foul.fs", 16'(false_start), 16'd1);
        check("foul.led_seen", 16'(led_seen), 16'd0);
        check("foul.best", best_bcd, 16'h0250);
        check("foul.bcd", bcd_time, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 7'd0);
        check("foul.restart_fs", 16'(false_start), 16'd0);
        check("foul.restart_state", 16'(state_o), 16'd1);
        cycle(1'b0, 1'b1, 1'b0, '0);

        // Best tracking: 300, then 120, then tie at 120
        run_round(7'd2, 300);
        check("best300.bcd", bcd_time, 16'h0300);
        check("best300.best", best_bcd, 16'h0250);
        run_round(7'd9, 120);
        check("best120.best", best_bcd, 16'h0120);
        run_round(7'd0, 120);
        check("tie120.best", best_bcd, 16'h0120);
        check_model("best");

        // Saturation
        cycle(1'b1, 1'b0, 1'b0, 7'd0);
        for (int i = 0; i < MIN + 10050; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        check("sat.bcd", bcd_time, 16'h9999);
        check("sat.state", 16'(state_o), 16'd2);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("sat.best", best_bcd, 16'h0120);

        // Stop together with a tick at 0099
        cycle(1'b1, 1'b0, 1'b0, 7'd1);
        for (int i = 0; i < MIN + SCALE + 99; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        check("stoptick.pre", bcd_time, 16'h0099);
        cycle(1'b0, 1'b1, 1'b1, '0);
        check("stoptick.bcd", bcd_time, 16'h0099);
        check("stoptick.state", 16'(state_o), 16'd3);
        check("stoptick.best", best_bcd, 16'h0099);

        // Async reset mid-RUN at 0042
        cycle(1'b1, 1'b0, 1'b0, 7'd0);
        for (int i = 0; i < MIN + 42; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        check("arst.pre", bcd_time, 16'h0042);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst.state", 16'(state_o), 16'd0);
        check("arst.bcd", bcd_time, 16'h0000);
        check("arst.best", best_bcd, 16'h9999);
        check("arst.led", 16'(led_go), 16'd0);
        check("arst.running", 16'(running), 16'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 199) == 0);
            tk = $urandom_range(0, 1) == 1;
            cycle(st, sp, tk, 7'($urandom_range(0, 127)));
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Sequencing controller for the stopwatch/reaction-timer datapath on the DE-10 Lite.
- Takes the 1 kHz tick from the clock divider, the button pulses, and a 7-bit pseudo-random value from the LFSR.
- Runs a random pre-delay, lights the GO LED, then counts elapsed milliseconds in BCD until stop.
- Tracks false starts and the best (lowest) reaction time for the seven-segment display path.

Parameters:
- MIN_DELAY_MS, 1000: fixed part of the pre-delay, in ticks.
- DELAY_SCALE, 16: ticks added per LSB of rand_in. MIN_DELAY_MS + 127*DELAY_SCALE must be ≤ 65535.

Ports:
- clk  input  1  system clock (50 MHz on board).
- reset  input  1  asynchronous, active-high reset.
- tick_ms  input  1  one-clk-wide pulse per millisecond, synchronous to clk.
- start_btn  input  1  one-clk-wide pulse, debounced and synchronized upstream.
- stop_btn  input  1  one-clk-wide pulse, debounced and synchronized upstream.
- rand_in  input  7  LFSR value, sampled on an accepted start.
- led_go  output  1  high while in RUN.
- running  output  1  high in DELAY or RUN.
- false_start  output  1  sticky flag, set when stop is pressed during DELAY.
- bcd_time  output  16  current time as 4 BCD digits, [15:12] thousands … [3:0] units, ms.
- best_bcd  output  16  best time so far, 4 BCD digits.
- state_o  output  3  encoded state, for debug LEDs.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All outputs and registers are registered and update on posedge clk.
- Reset values:
  - state = IDLE (0), led_go = 0, running = 0, false_start = 0, bcd_time = 16'h0000.
  - best_bcd = 16'h9999; delay counter = 0.
  - Reset asserted mid-operation aborts immediately to these values, including best_bcd.
- State encoding: IDLE = 0, DELAY = 1, RUN = 2, DONE = 3, FOUL = 4. Codes 5–7 recover to IDLE on the next edge.
- IDLE:
  - start_btn → DELAY.
  - On the same edge: delay_cnt (16 bit) = MIN_DELAY_MS + rand_in*DELAY_SCALE, computed in 16-bit unsigned; bcd_time cleared to 0; false_start cleared.
  - stop_btn ignored.
- DELAY:
  - Each tick_ms decrements delay_cnt.
  - When tick_ms arrives with delay_cnt == 1 (or delay_cnt == 0, guarding MIN = 0 with rand_in = 0): → RUN with led_go = 1 on that edge.
  - stop_btn → FOUL with false_start = 1; stop has priority over a simultaneous tick.
  - start_btn ignored.
- RUN:
  - Each tick_ms increments bcd_time as a 4-digit BCD counter; a units carry ripples within the same cycle.
  - Saturates at 16'h9999 and stays in RUN.
  - stop_btn → DONE, freezing bcd_time; a tick in the same cycle is not counted. led_go = 0 on that edge.
  - On that same edge, if bcd_time < best_bcd, best_bcd ← bcd_time. Packed BCD compares correctly as unsigned binary; equal values do not update.
  - start_btn ignored.
- DONE: bcd_time held. start_btn → DELAY with a fresh load, exactly as from IDLE. stop_btn ignored.
- FOUL: false_start held at 1, bcd_time held at 0. start_btn → DELAY and clears false_start.
- start_btn and stop_btn asserted in the same cycle: stop takes precedence in DELAY and RUN; start takes precedence in IDLE, DONE and FOUL.
- running = 1 exactly in DELAY and RUN.
- Latency: one clk from the qualifying input pulse to the visible state/output change. The DELAY phase lasts exactly MIN_DELAY_MS + rand_in*DELAY_SCALE tick_ms pulses.

Test Plan:
- Post-reset check:
  - Stimulus: reset pulse, then hold.
  - Required response: state_o = 0, bcd_time = 0000, best_bcd = 9999, led_go = 0, false_start = 0.
- Normal round (MIN = 4, SCALE = 1):
  - Stimulus: start with rand_in = 3; led_go must rise on the edge of the 7th tick. Then 250 ticks, then stop.
  - Required response: bcd_time = 0250, best_bcd = 0250, state = DONE.
- False start:
  - Stimulus: start, then stop after 2 ticks.
  - Required response: state = FOUL, false_start = 1, led_go never high, best_bcd unchanged. A subsequent start clears false_start.
- Best tracking:
  - Stimulus: rounds of 0250, then 0300, then 0120.
  - Required response: best_bcd = 0250, then 0250, then 0120. A tie at 0120 leaves it unchanged.
- Saturation and simultaneous events:
  - Stimulus: 10 050 ticks in RUN.
  - Required response: bcd_time = 9999, state still RUN.
  - Stimulus: stop asserted together with a tick at 0099.
  - Required response: bcd_time = 0099.
- Async reset mid-RUN:
  - Stimulus: assert reset between clk edges at bcd_time = 0042.
  - Required response: outputs take reset values immediately, without waiting for a clk edge; best_bcd returns to 9999.
